// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, burst constants and divisor-to-count helper for the LED sequencer
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_BURST = 2'd3
    } led_mode_e;

    typedef enum logic {
        FLASH = 1'b0,
        GAP   = 1'b1
    } burst_state_e;

    localparam int BURST_TOGGLES = 4;
    localparam int BURST_GAP     = 4;

    // Out-of-range divisors fall back to the slowest rate (div 1).
    function automatic int calc_cnt_max(input int clk_hz, input int div, input int div_max);
        if (div == 0 || div > div_max) begin
            return clk_hz;
        end
        return clk_hz / div;
    endfunction

endpackage

// File: rtl/led_ch.sv
// rtl/led_ch.sv - one LED channel: config registers, wrap counter, burst FSM, led/tick outputs
module led_ch
    import led_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int CNT_W  = $clog2(CLK_HZ + 1)
) (
    input  logic             clk100,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  led_mode_e        wr_mode_i,
    input  logic [CNT_W-1:0] wr_cnt_max_i,
    input  logic             sync_i,
    output logic             led_o,
    output logic             tick_o
);

    localparam int PH_MAX = (BURST_TOGGLES > BURST_GAP) ? BURST_TOGGLES : BURST_GAP;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    led_mode_e        mode_q, mode_d;
    burst_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_max_q, cnt_max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             led_q, led_d;
    logic             tick_q, tick_d;
    logic             wrap;

    assign wrap = (cnt_q == cnt_max_q);

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            mode_q    <= LED_OFF;
            state_q   <= FLASH;
            cnt_max_q <= CNT_W'(CLK_HZ);
            cnt_q     <= '0;
            phase_q   <= '0;
            led_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            state_q   <= state_d;
            cnt_max_q <= cnt_max_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            led_q     <= led_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        mode_d    = mode_q;
        state_d   = state_q;
        cnt_max_d = cnt_max_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        led_d     = led_q;
        tick_d    = 1'b0;

        if (wr_en_i) begin
            // A write restarts the channel; ON lights immediately so every mode has one-cycle latency.
            mode_d    = wr_mode_i;
            cnt_max_d = wr_cnt_max_i;
            cnt_d     = '0;
            state_d   = FLASH;
            phase_d   = '0;
            led_d     = (wr_mode_i == LED_ON);
        end else if (sync_i && (mode_q == LED_BLINK || mode_q == LED_BURST)) begin
            cnt_d   = '0;
            state_d = FLASH;
            phase_d = '0;
            led_d   = 1'b0;
        end else begin
            case (mode_q)
                LED_OFF: begin
                    cnt_d = '0;
                    led_d = 1'b0;
                end
                LED_ON: begin
                    cnt_d = '0;
                    led_d = 1'b1;
                end
                LED_BLINK: begin
                    if (wrap) begin
                        cnt_d  = '0;
                        led_d  = ~led_q;
                        tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                LED_BURST: begin
                    if (!wrap) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                        if (state_q == FLASH) begin
                            led_d  = ~led_q;
                            tick_d = 1'b1;
                            if (phase_q == PH_W'(BURST_TOGGLES - 1)) begin
                                state_d = GAP;
                                phase_d = '0;
                            end else begin
                                phase_d = phase_q + PH_W'(1);
                            end
                        end else begin
                            led_d = 1'b0;
                            if (phase_q == PH_W'(BURST_GAP - 1)) begin
                                state_d = FLASH;
                                phase_d = '0;
                            end else begin
                                phase_d = phase_q + PH_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    cnt_d = '0;
                    led_d = 1'b0;
                end
            endcase
        end
    end

    assign led_o  = led_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/led_blink_multi.sv
// rtl/led_blink_multi.sv - multi-channel LED sequencer top; LED_PWM_DIM_EN adds shared PWM dimming
module led_blink_multi
    import led_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CLK_HZ  = 100000000,
    parameter int DIV_W   = 5,
    parameter int DIV_MAX = 20,
`ifdef LED_PWM_DIM_EN
    parameter int DIM_DUTY = 64,
`endif
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk100,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [CH_W-1:0]   wr_ch_i,
    input  logic [1:0]        wr_mode_i,
    input  logic [DIV_W-1:0]  wr_div_i,
    input  logic              sync_i,
    output logic [NUM_CH-1:0] led_o,
    output logic [NUM_CH-1:0] tick_o
);

    localparam int CNT_W   = $clog2(CLK_HZ + 1);
    localparam int LUT_LEN = 2 ** DIV_W;

    logic [CNT_W-1:0]  cnt_lut [LUT_LEN];
    logic [CNT_W-1:0]  wr_cnt_max;
    logic [NUM_CH-1:0] led_raw;

    // Every divisor's count is a constant, so the write path is a table read rather than a divider.
    for (genvar d = 0; d < LUT_LEN; d++) begin : g_lut
        assign cnt_lut[d] = CNT_W'(calc_cnt_max(CLK_HZ, d, DIV_MAX));
    end

    assign wr_cnt_max = cnt_lut[wr_div_i];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ch_wr;

        assign ch_wr = wr_en_i && (wr_ch_i == CH_W'(g));

        led_ch #(
            .CLK_HZ (CLK_HZ),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk100       (clk100),
            .rst_n        (rst_n),
            .wr_en_i      (ch_wr),
            .wr_mode_i    (led_mode_e'(wr_mode_i)),
            .wr_cnt_max_i (wr_cnt_max),
            .sync_i       (sync_i),
            .led_o        (led_raw[g]),
            .tick_o       (tick_o[g])
        );
    end

`ifdef LED_PWM_DIM_EN
    logic [7:0] pwm_cnt_q, pwm_cnt_d;
    logic       pwm_on;

    assign pwm_cnt_d = pwm_cnt_q + 8'd1;

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign pwm_on = (int'(pwm_cnt_q) < DIM_DUTY);
    assign led_o  = led_raw & {NUM_CH{pwm_on}};
`else
    assign led_o = led_raw;
`endif

endmodule

// File: tb/tb_led_blink_multi.sv
// tb/tb_led_blink_multi.sv - scoreboard bench for led_blink_multi using a cycle-age reference model
module tb_led_blink_multi;

    localparam int NUM_CH  = 5;
    localparam int CLK_HZ  = 100;
    localparam int DIV_W   = 5;
    localparam int DIV_MAX = 20;
    localparam int CH_W    = 3;
    localparam int EW      = 2 * NUM_CH;

    logic              clk100 = 1'b0;
    logic              rst_n;
    logic              wr_en_i;
    logic [CH_W-1:0]   wr_ch_i;
    logic [1:0]        wr_mode_i;
    logic [DIV_W-1:0]  wr_div_i;
    logic              sync_i;
    logic [NUM_CH-1:0] led_o;
    logic [NUM_CH-1:0] tick_o;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] sb_q [$];
    int            m_mode [NUM_CH];
    int            m_hp   [NUM_CH];
    int            m_t    [NUM_CH];
    int            m_n;
    int            m_pwm;
    logic [NUM_CH-1:0] m_led, m_tick;

    always #5 clk100 = ~clk100;

    led_blink_multi #(
        .NUM_CH  (NUM_CH),
        .CLK_HZ  (CLK_HZ),
        .DIV_W   (DIV_W),
        .DIV_MAX (DIV_MAX)
    ) dut (
        .clk100    (clk100),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en_i),
        .wr_ch_i   (wr_ch_i),
        .wr_mode_i (wr_mode_i),
        .wr_div_i  (wr_div_i),
        .sync_i    (sync_i),
        .led_o     (led_o),
        .tick_o    (tick_o)
    );

    function automatic int half_period(input int div);
        if (div == 0 || div > DIV_MAX) return CLK_HZ + 1;
        return CLK_HZ / div + 1;
    endfunction

    // Model: t = cycles since the channel last restarted; led/tick follow from t and the half period.
    initial begin
        m_pwm = 0;
        forever begin
            @(posedge clk100);
            m_led  = '0;
            m_tick = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (!rst_n) begin
                    m_mode[ch] = 0;
                    m_hp[ch]   = CLK_HZ + 1;
                    m_t[ch]    = 0;
                end else if (wr_en_i && int'(wr_ch_i) == ch) begin
                    m_mode[ch] = int'(wr_mode_i);
                    m_hp[ch]   = half_period(int'(wr_div_i));
                    m_t[ch]    = 0;
                end else if (m_mode[ch] >= 2) begin
                    m_t[ch] = sync_i ? 0 : m_t[ch] + 1;
                end
                m_n = m_t[ch] / m_hp[ch];
                case (m_mode[ch])
                    1: m_led[ch] = 1'b1;
                    2: begin
                        m_led[ch]  = (m_n % 2) == 1;
                        m_tick[ch] = m_t[ch] > 0 && (m_t[ch] % m_hp[ch]) == 0;
                    end
                    3: begin
                        m_led[ch]  = (m_n % 8) == 1 || (m_n % 8) == 3;
                        m_tick[ch] = m_t[ch] > 0 && (m_t[ch] % m_hp[ch]) == 0 && ((m_n - 1) % 8) < 4;
                    end
                    default: m_led[ch] = 1'b0;
                endcase
            end
`ifdef LED_PWM_DIM_EN
            m_pwm = !rst_n ? 0 : (m_pwm + 1) % 256;
            if (m_pwm >= 64) m_led = '0;
`endif
            sb_q.push_back({m_led, m_tick});
        end
    end

    task automatic test_reset();
        logic [EW-1:0] exp;
        rst_n = 1'b0; wr_en_i = 1'b0; wr_ch_i = '0; wr_mode_i = '0; wr_div_i = '0; sync_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk100); #1;
            if (i == 3) rst_n = 1'b1;
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL reset scoreboard empty"); end
            else begin
                exp = sb_q.pop_front();
                if ({led_o, tick_o} !== exp) begin
                    errors++; $display("FAIL reset led=%b tick=%b expected led=%b tick=%b", led_o, tick_o, exp[EW-1:NUM_CH], exp[NUM_CH-1:0]);
                end
            end
        end
    endtask

    task automatic test_blink();
        logic [EW-1:0] exp;
        int ticks = 0;
        wr_en_i = 1'b1; wr_ch_i = 3'd0; wr_mode_i = 2'd2; wr_div_i = 5'd2;
        repeat (160) begin
            @(posedge clk100); #1;
            wr_en_i = 1'b0;
            ticks += int'(tick_o[0]);
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL blink scoreboard empty"); end
            else begin
                exp = sb_q.pop_front();
                if ({led_o, tick_o} !== exp) begin
                    errors++; $display("FAIL blink t=%0t led=%b tick=%b expected led=%b tick=%b", $time, led_o, tick_o, exp[EW-1:NUM_CH], exp[NUM_CH-1:0]);
                end
            end
        end
        checks++;
        if (ticks !== 3) begin errors++; $display("FAIL blink_tick_count got %0d expected 3", ticks); end
    endtask

    task automatic test_div_clamp();
        logic [EW-1:0] exp;
        int t1 = 0, t4 = 0;
        wr_en_i = 1'b1; wr_ch_i = 3'd1; wr_mode_i = 2'd2; wr_div_i = 5'd0;
        for (int i = 0; i < 221; i++) begin
            @(posedge clk100); #1;
            if (i == 0) begin wr_ch_i = 3'd4; wr_div_i = 5'd25; end
            else wr_en_i = 1'b0;
            t1 += int'(tick_o[1]);
            if (i > 0) t4 += int'(tick_o[4]);
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL div_clamp scoreboard empty"); end
            else begin
                exp = sb_q.pop_front();
                if ({led_o, tick_o} !== exp) begin
                    errors++; $display("FAIL div_clamp t=%0t led=%b tick=%b expected led=%b tick=%b", $time, led_o, tick_o, exp[EW-1:NUM_CH], exp[NUM_CH-1:0]);
                end
            end
        end
        checks++;
        if (t1 !== 2 || t4 !== 2) begin errors++; $display("FAIL div_clamp_ticks got ch1=%0d ch4=%0d expected 2 2", t1, t4); end
    endtask

    task automatic test_burst();
        logic [EW-1:0] exp;
        int ticks = 0;
        wr_en_i = 1'b1; wr_ch_i = 3'd2; wr_mode_i = 2'd3; wr_div_i = 5'd4;
        repeat (416) begin
            @(posedge clk100); #1;
            wr_en_i = 1'b0;
            ticks += int'(tick_o[2]);
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL burst scoreboard empty"); end
            else begin
                exp = sb_q.pop_front();
                if ({led_o, tick_o} !== exp) begin
                    errors++; $display("FAIL burst t=%0t led=%b tick=%b expected led=%b tick=%b", $time, led_o, tick_o, exp[EW-1:NUM_CH], exp[NUM_CH-1:0]);
                end
            end
        end
        checks++;
        if (ticks !== 8) begin errors++; $display("FAIL burst_tick_count got %0d expected 8", ticks); end
    endtask

    task automatic test_sync();
        logic [EW-1:0] exp;
        int skew = 0;
        wr_en_i = 1'b1; wr_ch_i = 3'd3; wr_mode_i = 2'd2; wr_div_i = 5'd2;
        for (int i = 0; i < 151; i++) begin
            @(posedge clk100); #1;
            wr_en_i = (i == 0);
            wr_ch_i = 3'd4; wr_mode_i = 2'd1;
            sync_i = (i == 29);
            if (i > 30 && led_o[0] !== led_o[3]) skew++;
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL sync scoreboard empty"); end
            else begin
                exp = sb_q.pop_front();
                if ({led_o, tick_o} !== exp) begin
                    errors++; $display("FAIL sync t=%0t led=%b tick=%b expected led=%b tick=%b", $time, led_o, tick_o, exp[EW-1:NUM_CH], exp[NUM_CH-1:0]);
                end
            end
        end
        checks++;
        if (skew !== 0) begin errors++; $display("FAIL sync_alignment got %0d skewed cycles expected 0", skew); end
    endtask

    task automatic test_write_sync_wrap();
        logic [EW-1:0] exp;
        wr_en_i = 1'b1; wr_ch_i = 3'd1; wr_mode_i = 2'd2; wr_div_i = 5'd2;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk100); #1;
            wr_en_i = (i == 50) || (i == 100);
            sync_i  = (i == 50);
            wr_ch_i = (i == 100) ? 3'd5 : 3'd1;
            wr_mode_i = (i == 100) ? 2'd0 : 2'd3;
            wr_div_i  = 5'd4;
            if (i == 51 && tick_o[1] !== 1'b0) begin
                errors++; $display("FAIL wrap_write_tick got %b expected 0", tick_o[1]);
            end
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL wsw scoreboard empty"); end
            else begin
                exp = sb_q.pop_front();
                if ({led_o, tick_o} !== exp) begin
                    errors++; $display("FAIL wsw t=%0t led=%b tick=%b expected led=%b tick=%b", $time, led_o, tick_o, exp[EW-1:NUM_CH], exp[NUM_CH-1:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [EW-1:0] exp;
        rst_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk100); #1;
            rst_n = 1'b1;
            if (i == 0 && {led_o, tick_o} !== '0) begin
                errors++; $display("FAIL reset_mid_outputs got led=%b tick=%b expected 0", led_o, tick_o);
            end
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL reset_mid scoreboard empty"); end
            else begin
                exp = sb_q.pop_front();
                if ({led_o, tick_o} !== exp) begin
                    errors++; $display("FAIL reset_mid t=%0t led=%b tick=%b expected led=%b tick=%b", $time, led_o, tick_o, exp[EW-1:NUM_CH], exp[NUM_CH-1:0]);
                end
            end
        end
    endtask

`ifdef LED_PWM_DIM_EN
    task automatic test_pwm();
        logic [EW-1:0] exp;
        int high = 0;
        wr_en_i = 1'b1; wr_ch_i = 3'd0; wr_mode_i = 2'd1; wr_div_i = 5'd0;
        for (int i = 0; i < 513; i++) begin
            @(posedge clk100); #1;
            wr_en_i = 1'b0;
            if (i > 0) high += int'(led_o[0]);
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL pwm scoreboard empty"); end
            else begin
                exp = sb_q.pop_front();
                if ({led_o, tick_o} !== exp) begin
                    errors++; $display("FAIL pwm t=%0t led=%b tick=%b expected led=%b tick=%b", $time, led_o, tick_o, exp[EW-1:NUM_CH], exp[NUM_CH-1:0]);
                end
            end
        end
        checks++;
        if (high !== 128) begin errors++; $display("FAIL pwm_duty got %0d expected 128", high); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_blink();
        test_div_clamp();
        test_burst();
        test_sync();
        test_write_sync_wrap();
        test_reset_mid();
`ifdef LED_PWM_DIM_EN
        test_pwm();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
